// File: rtl/gps_lut_interp.sv
// Table-lookup linear interpolator: binary-searches a monotonic {x,y} ROM and divides restoringly.
// Optional GPS_LUT_INTERP_ROUND_EN: round quotient half away from zero (one extra DIV cycle).
module gps_lut_interp #(
  parameter int XW = 48,
  parameter int YW = 48,
  parameter int AW = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW-1:0]    x_in,
  output logic [AW-1:0]    rom_addr,
  input  logic [XW+YW-1:0] rom_data,
  output logic             out_valid,
  output logic [YW-1:0]    y_out,
  output logic [1:0]       out_range
);
`ifdef GPS_LUT_INTERP_ROUND_EN
  localparam int QW = YW + 1;
`else
  localparam int QW = YW;
`endif
  localparam int CW = $clog2(QW + AW + 2);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  typedef enum logic [3:0] {
    IDLE, CHK_LO, CHK_HI, SEARCH, LOAD0, LOAD1, MUL, DIV, DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] rom_addr_q, k_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q, x0_q, x1_q, dxx_q, rem_q;
  logic [YW-1:0] y0_q, y1_q, pl_q, y_out_q;
  logic [QW-2:0] quo_q;
  logic          sign_q, out_valid_q;
  logic [1:0]    out_range_q;
`ifdef GPS_LUT_INTERP_ROUND_EN
  logic [YW-1:0] dy_q;
`endif

  logic [XW-1:0]    rom_x;
  logic [YW-1:0]    rom_y;
  logic [AW-1:0]    k_d, trial_d;
  logic [XW-1:0]    dx_d, dxx_d, rem_d;
  logic [YW-1:0]    ady_d, q_mag_d, q_fin_d, y_fin_d;
  logic             sign_d, qbit_d;
  logic [XW+YW-1:0] p_d;
  logic [XW:0]      r2_d;
  logic [QW-1:0]    q_full_d;
`ifdef GPS_LUT_INTERP_ROUND_EN
  logic [QW:0]      q_rnd_d;
`endif

  assign rom_x     = rom_data[XW+YW-1:YW];
  assign rom_y     = rom_data[YW-1:0];
  assign in_ready  = (state_q == IDLE);
  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_out_q;
  assign out_range = out_range_q;

  // Search: rom_addr holds the current trial, cnt_q its bit position
  assign k_d     = (rom_x <= x_q) ? rom_addr_q : k_q;
  assign trial_d = k_d | (ONE_A << (cnt_q - CW'(1)));

  always_comb begin
    dx_d   = x_q - x0_q;
    dxx_d  = x1_q - x0_q;
    sign_d = (y1_q < y0_q);
    ady_d  = sign_d ? (y0_q - y1_q) : (y1_q - y0_q);
    p_d    = (XW+YW)'(dx_d) * (XW+YW)'(ady_d);
  end

  // The high part of P is always below dX, so YW (+1) shift steps suffice
  always_comb begin
    r2_d     = {rem_q, pl_q[YW-1]};
    qbit_d   = (r2_d >= {1'b0, dxx_q});
    rem_d    = qbit_d ? (r2_d[XW-1:0] - dxx_q) : r2_d[XW-1:0];
    q_full_d = {quo_q, qbit_d};
`ifdef GPS_LUT_INTERP_ROUND_EN
    q_rnd_d  = ({1'b0, q_full_d} + (QW+1)'(1)) >> 1;
    q_mag_d  = (q_rnd_d > (QW+1)'(dy_q)) ? dy_q : q_rnd_d[YW-1:0];
`else
    q_mag_d  = q_full_d;
`endif
    q_fin_d  = (dxx_q == '0) ? '0 : q_mag_d;
    y_fin_d  = sign_q ? (y0_q - q_fin_d) : (y0_q + q_fin_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      out_range_q <= 2'b00;
      k_q         <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      dxx_q       <= '0;
      rem_q       <= '0;
      pl_q        <= '0;
      quo_q       <= '0;
      sign_q      <= 1'b0;
`ifdef GPS_LUT_INTERP_ROUND_EN
      dy_q        <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q        <= x_in;
          rom_addr_q <= '0;
          state_q    <= CHK_LO;
        end
        CHK_LO: if (x_q < rom_x) begin
          y_out_q     <= rom_y;
          out_range_q <= 2'b01;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end else begin
          rom_addr_q <= '1;
          state_q    <= CHK_HI;
        end
        CHK_HI: if (x_q >= rom_x) begin
          y_out_q     <= rom_y;
          out_range_q <= (x_q > rom_x) ? 2'b10 : 2'b00;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end else begin
          k_q        <= '0;
          cnt_q      <= CW'(AW - 1);
          rom_addr_q <= ONE_A << (AW - 1);
          state_q    <= SEARCH;
        end
        SEARCH: begin
          k_q <= k_d;
          if (cnt_q == '0) begin
            rom_addr_q <= k_d;
            state_q    <= LOAD0;
          end else begin
            cnt_q      <= cnt_q - CW'(1);
            rom_addr_q <= trial_d;
          end
        end
        LOAD0: begin
          x0_q       <= rom_x;
          y0_q       <= rom_y;
          rom_addr_q <= k_q + ONE_A;
          state_q    <= LOAD1;
        end
        LOAD1: begin
          x1_q    <= rom_x;
          y1_q    <= rom_y;
          state_q <= MUL;
        end
        MUL: begin
          dxx_q         <= dxx_d;
          sign_q        <= sign_d;
          {rem_q, pl_q} <= p_d;
          quo_q         <= '0;
          cnt_q         <= CW'(QW);
`ifdef GPS_LUT_INTERP_ROUND_EN
          dy_q          <= ady_d;
`endif
          state_q       <= DIV;
        end
        DIV: begin
          rem_q <= rem_d;
          pl_q  <= {pl_q[YW-2:0], 1'b0};
          quo_q <= q_full_d[QW-2:0];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            y_out_q     <= y_fin_d;
            out_range_q <= 2'b00;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gps_lut_interp.sv
// Bench for gps_lut_interp: directed and random monotonic tables checked against an arithmetic interpolation model.
module tb_gps_lut_interp;
  localparam int XW = 48;
  localparam int YW = 48;
  localparam int AW = 7;
  localparam int DEPTH = 1 << AW;
`ifdef GPS_LUT_INTERP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT_MID = AW + YW + 5 + (RND ? 1 : 0);

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid;
  logic [XW-1:0]    x_in;
  logic [AW-1:0]    rom_addr;
  logic [XW+YW-1:0] rom_data;
  logic [YW-1:0]    y_out;
  logic [1:0]       out_range;

  logic [XW-1:0] xs [DEPTH];
  logic [YW-1:0] ys [DEPTH];

  int n_checks = 0;
  int n_pass = 0;

  gps_lut_interp #(.XW(XW), .YW(YW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .y_out(y_out), .out_range(out_range)
  );

  assign rom_data = {xs[rom_addr], ys[rom_addr]};
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: linear scan for the bracket, exact wide arithmetic for the interpolation
  task automatic model(input logic [XW-1:0] x, output logic [YW-1:0] y,
                       output logic [1:0] rng, output int lat);
    logic [127:0] dx, ddx, ady, p, q;
    int k;
    if (x < xs[0]) begin
      y = ys[0]; rng = 2'b01; lat = 1;
    end else if (x >= xs[DEPTH-1]) begin
      y = ys[DEPTH-1]; rng = (x > xs[DEPTH-1]) ? 2'b10 : 2'b00; lat = 2;
    end else begin
      k = 0;
      for (int i = 0; i < DEPTH; i++) if (xs[i] <= x) k = i;
      dx  = 128'(x) - 128'(xs[k]);
      ddx = 128'(xs[k+1]) - 128'(xs[k]);
      ady = (ys[k+1] >= ys[k]) ? 128'(ys[k+1]) - 128'(ys[k]) : 128'(ys[k]) - 128'(ys[k+1]);
      p   = dx * ady;
      if (RND) begin
        q = (2 * p + ddx) / (2 * ddx);
        if (q > ady) q = ady;
      end else begin
        q = p / ddx;
      end
      y   = YW'((ys[k+1] >= ys[k]) ? 128'(ys[k]) + q : 128'(ys[k]) - q);
      rng = 2'b00;
      lat = LAT_MID;
    end
  endtask

  task automatic run_req(input string tag, input logic [XW-1:0] x, input bit poke);
    logic [YW-1:0] ey;
    logic [1:0]    er;
    int            el, n, extra;
    model(x, ey, er, el);
    @(negedge clk);
    check({tag, ".rdy"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = ~x;
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid = poke && (n == 3 || n == 20);
      if (poke && n == 3) check({tag, ".busy"}, 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, 128'(n), 128'(el));
    check({tag, ".y"}, 128'(y_out), 128'(ey));
    check({tag, ".rng"}, 128'(out_range), 128'(er));
    @(posedge clk); #1;
    check({tag, ".vld_drop"}, 128'(out_valid), 128'(0));
    check({tag, ".rdy_back"}, 128'(in_ready), 128'(1));
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (out_valid) extra++;
      end
      check({tag, ".no_extra"}, 128'(extra), 128'(0));
    end
  endtask

  task automatic make_table(input int mode);
    logic [63:0] acc, r, yr;
    acc = 64'($urandom_range(1, 1000));
    for (int i = 0; i < DEPTH; i++) begin
      r  = {$urandom, $urandom};
      yr = {$urandom, $urandom};
      if (mode == 0) acc = acc + 64'd1 + (r % 64'd8);
      else           acc = acc + 64'd1 + (r % (64'd1 << 39));
      xs[i] = acc[XW-1:0];
      ys[i] = yr[YW-1:0];
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [XW-1:0] x;
    int sel, cnt;
    reset = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    for (int i = 0; i < DEPTH; i++) begin
      xs[i] = XW'(1000 * i);
      ys[i] = YW'(1000000 - 500 * i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst.rdy", 128'(in_ready), 128'(1));
    check("rst.vld", 128'(out_valid), 128'(0));
    check("rst.y", 128'(y_out), 128'(0));
    check("rst.rng", 128'(out_range), 128'(0));
    check("rst.addr", 128'(rom_addr), 128'(0));
    reset = 1'b0;

    run_req("lin", XW'(2500), 1'b0);
    check("lin.const", 128'(y_out), 128'(998750));

    for (int i = 0; i < DEPTH; i++) begin xs[i] = XW'(3 * i); ys[i] = YW'(4 * i); end
    run_req("inc", XW'(5), 1'b0);
    check("inc.const", 128'(y_out), RND ? 128'(7) : 128'(6));

    for (int i = 0; i < DEPTH; i++) begin xs[i] = XW'(3 * i); ys[i] = YW'(100 - 4 * i); end
    run_req("dec", XW'(5), 1'b1);
    check("dec.const", 128'(y_out), RND ? 128'(93) : 128'(94));

    for (int i = 0; i < DEPTH; i++) begin xs[i] = XW'(3 * i + 10); ys[i] = YW'(7 * i + 1); end
    run_req("below", XW'(5), 1'b0);
    run_req("top_eq", xs[DEPTH-1], 1'b0);
    run_req("above", xs[DEPTH-1] + XW'(9), 1'b0);
    run_req("hit37", xs[37], 1'b0);
    check("hit37.const", 128'(y_out), 128'(ys[37]));

    // Abort in the middle of the divide
    @(negedge clk);
    in_valid = 1'b1; x_in = XW'(200);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.rdy", 128'(in_ready), 128'(1));
    check("abort.vld", 128'(out_valid), 128'(0));
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("abort.silent", 128'(cnt), 128'(0));
    run_req("after_abort", XW'(200), 1'b0);

    for (int t = 0; t < 36; t++) begin
      if (t % 9 == 0) make_table((t / 9) % 2);
      sel = $urandom_range(0, 9);
      r = {$urandom, $urandom};
      case (sel)
        0: x = xs[0] - XW'(1);
        1: x = xs[DEPTH-1] + XW'(r % 64'd50);
        2: x = xs[$urandom_range(0, DEPTH-1)];
        default: x = xs[0] + XW'(r % 64'(xs[DEPTH-1] - xs[0]));
      endcase
      run_req("rnd", x, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
